keypad_scanner: RTL and testbench

Drives and reads the 4x3 telephone-style matrix keypad on the PMOD header. It produces the debounced key_valid / key_code interface that the lock FSM consumes.
- Scans rows, synchronises and debounces the columns, and encodes the key.
- Holds key_valid high for as long as exactly one key is stably pressed; the consumer does its own rising-edge detection.

---
 rtl/keypad_pkg.sv | 34 +++
 rtl/sync_2ff.sv | 28 ++
 rtl/keypad_scanner.sv | 222 ++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, matrix geometry, scan-result type and layout lookup
// shared by the keypad scanner and the lock FSM.
package keypad_pkg;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  localparam int N_ROWS = 4;
  localparam int N_COLS = 3;

  // Outcome of one complete four-row scan
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } scan_res_e;

  // Telephone layout: rows 0..2 carry digits 1..9, row 3 carries * 0 #
  function automatic logic [3:0] encode_key(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'h0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops; only sync_q may be consumed downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: drives the 4x3 keypad rows, synchronises the columns,
// filters whole-scan results and reports a debounced key / multi-key press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROW_DWELL    = 125_000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row_n,
  input  logic [2:0] col_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       multi_key
);

  localparam int DW_W  = $clog2(ROW_DWELL);
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(ROW_DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE_CNT);
  localparam logic [1:0]       LAST_ROW   = 2'(N_ROWS - 1);

  typedef enum logic [1:0] {RELEASED, PRESSED, BLOCKED} db_state_e;

  logic [2:0]       col_sync;

  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       row_n_q, row_n_d;
  logic [1:0]       hits_q, hits_d;
  logic [3:0]       acc_code_q, acc_code_d;

  logic [2:0]       row_low;
  logic [1:0]       row_hits;
  logic [3:0]       row_code;
  logic [1:0]       sum_hits;
  logic [3:0]       sum_code;
  logic             res_vld;
  scan_res_e        res_type;
  logic [3:0]       res_code;

  scan_res_e        cand_type_q, cand_type_d;
  logic [3:0]       cand_code_q, cand_code_d;
  logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
  logic             commit_q, commit_d;
  scan_res_e        commit_type_q;
  logic [3:0]       commit_code_q;

  db_state_e        state_q;
  logic             key_valid_q;
  logic [3:0]       key_code_q;
  logic             multi_key_q;

  sync_2ff #(
    .WIDTH   (N_COLS),
    .RST_VAL ('1)
  ) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d_i (col_n),
    .q_o (col_sync)
  );

  // Row dwell timing plus per-scan accumulation of pressed intersections
  always_comb begin
    dwell_d    = dwell_q + DW_W'(1);
    row_d      = row_q;
    row_n_d    = row_n_q;
    hits_d     = hits_q;
    acc_code_d = acc_code_q;
    res_vld    = 1'b0;
    res_type   = NONE;
    res_code   = 4'h0;
    row_low    = ~col_sync;
    row_hits   = 2'd0;
    row_code   = 4'h0;
    for (int c = 0; c < N_COLS; c++) begin
      if (row_low[c]) begin
        row_hits = (row_hits == 2'd0) ? 2'd1 : 2'd2;
        row_code = encode_key(row_q, 2'(c));
      end
    end
    if (hits_q == 2'd0) begin
      sum_hits = row_hits;
    end else if (row_hits == 2'd0) begin
      sum_hits = hits_q;
    end else begin
      sum_hits = 2'd2;
    end
    sum_code = (row_hits != 2'd0) ? row_code : acc_code_q;
    if (dwell_q == DWELL_LAST) begin
      dwell_d = '0;
      row_d   = row_q + 2'd1;
      row_n_d = ~(4'b0001 << row_d);
      if (row_q == LAST_ROW) begin
        res_vld    = 1'b1;
        hits_d     = 2'd0;
        acc_code_d = 4'h0;
        if (sum_hits == 2'd0) begin
          res_type = NONE;
        end else if (sum_hits == 2'd1) begin
          res_type = SINGLE;
          res_code = sum_code;
        end else begin
          res_type = MULTI;
        end
      end else begin
        hits_d     = sum_hits;
        acc_code_d = sum_code;
      end
    end
  end

  // Scan counters and row drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q    <= '0;
      row_q      <= 2'd0;
      row_n_q    <= 4'b1110;
      hits_q     <= 2'd0;
      acc_code_q <= 4'h0;
    end else begin
      dwell_q    <= dwell_d;
      row_q      <= row_d;
      row_n_q    <= row_n_d;
      hits_q     <= hits_d;
      acc_code_q <= acc_code_d;
    end
  end

  // Candidate filter: commit once when a result repeats DEBOUNCE_CNT scans in a row
  always_comb begin
    cand_type_d  = cand_type_q;
    cand_code_d  = cand_code_q;
    stable_cnt_d = stable_cnt_q;
    commit_d     = 1'b0;
    if (res_vld) begin
      if (res_type == cand_type_q && res_code == cand_code_q) begin
        if (stable_cnt_q != CNT_MAX) begin
          stable_cnt_d = stable_cnt_q + CNT_W'(1);
          commit_d     = (stable_cnt_d == CNT_MAX);
        end
      end else begin
        cand_type_d  = res_type;
        cand_code_d  = res_code;
        stable_cnt_d = CNT_W'(1);
        commit_d     = (CNT_MAX == CNT_W'(1));
      end
    end
  end

  // Candidate state and the one-cycle commit strobe towards the FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_type_q   <= NONE;
      cand_code_q   <= 4'h0;
      stable_cnt_q  <= '0;
      commit_q      <= 1'b0;
      commit_type_q <= NONE;
      commit_code_q <= 4'h0;
    end else begin
      cand_type_q   <= cand_type_d;
      cand_code_q   <= cand_code_d;
      stable_cnt_q  <= stable_cnt_d;
      commit_q      <= commit_d;
      commit_type_q <= res_type;
      commit_code_q <= res_code;
    end
  end

  // Debounce FSM acting only on committed results; outputs registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RELEASED;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      multi_key_q <= 1'b0;
    end else if (commit_q) begin
      case (state_q)
        RELEASED: begin
          if (commit_type_q == SINGLE) begin
            key_code_q  <= commit_code_q;
            key_valid_q <= 1'b1;
            state_q     <= PRESSED;
          end else if (commit_type_q == MULTI) begin
            multi_key_q <= 1'b1;
            state_q     <= BLOCKED;
          end
        end
        PRESSED: begin
          if (commit_type_q == NONE) begin
            key_valid_q <= 1'b0;
            state_q     <= RELEASED;
          end else if (commit_type_q == MULTI) begin
            key_valid_q <= 1'b0;
            multi_key_q <= 1'b1;
            state_q     <= BLOCKED;
          end else if (commit_code_q != key_code_q) begin
            // Rollover to another key: drop it and wait for a full release
            key_valid_q <= 1'b0;
            state_q     <= BLOCKED;
          end
        end
        BLOCKED: begin
          if (commit_type_q == NONE) begin
            key_valid_q <= 1'b0;
            multi_key_q <= 1'b0;
            state_q     <= RELEASED;
          end
        end
        default: state_q <= RELEASED;
      endcase
    end
  end

  assign row_n     = row_n_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign multi_key = multi_key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix environment, scan-level reference model
// with per-cycle compare, and directed plus randomized press scenarios.
module tb_keypad_scanner;

  localparam int DW = 8;
  localparam int DC = 3;
  localparam logic [3:0] LAYOUT [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                        4'h7, 4'h8, 4'h9, 4'hA, 4'h0, 4'hB};
  localparam logic [3:0] ROW_SEQ [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam int R_NONE = 0, R_SINGLE = 1, R_MULTI = 2;
  localparam int S_REL = 0, S_PRS = 1, S_BLK = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row_n;
  logic [2:0] col_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       multi_key;
  logic [11:0] pressed;

  int n_checks = 0;
  int n_pass   = 0;

  keypad_scanner #(.ROW_DWELL(DW), .DEBOUNCE_CNT(DC)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .multi_key (multi_key)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_range(input string name, input int v, input int lo, input int hi);
    n_checks++;
    if (v >= lo && v <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
  endtask

  // ---------------- reference model ----------------
  int         m_k, m_hits, m_cand_t, m_cnt, m_pend_t, m_st;
  logic [3:0] m_code, m_cand_c, m_pend_c, m_key, m_row;
  logic       m_pend, m_kv, m_mk;
  logic [2:0] m_colq[$];

  task automatic model_reset();
    m_k = 0; m_hits = 0; m_code = 4'h0;
    m_cand_t = R_NONE; m_cand_c = 4'h0; m_cnt = 0;
    m_pend = 1'b0; m_pend_t = R_NONE; m_pend_c = 4'h0;
    m_st = S_REL; m_kv = 1'b0; m_key = 4'h0; m_mk = 1'b0; m_row = 4'b1110;
    m_colq.delete();
    m_colq.push_back(3'b111);
    m_colq.push_back(3'b111);
  endtask

  task automatic model_commit(input int t, input logic [3:0] c);
    case (m_st)
      S_REL: begin
        if (t == R_SINGLE) begin m_key = c; m_kv = 1'b1; m_st = S_PRS; end
        else if (t == R_MULTI) begin m_mk = 1'b1; m_st = S_BLK; end
      end
      S_PRS: begin
        if (t == R_NONE) begin m_kv = 1'b0; m_st = S_REL; end
        else if (t == R_MULTI) begin m_kv = 1'b0; m_mk = 1'b1; m_st = S_BLK; end
        else if (c != m_key) begin m_kv = 1'b0; m_st = S_BLK; end
      end
      default: begin
        if (t == R_NONE) begin m_kv = 1'b0; m_mk = 1'b0; m_st = S_REL; end
      end
    endcase
  endtask

  task automatic model_step();
    logic [2:0] seen;
    int d, r, t;
    logic [3:0] cc;
    if (m_pend) begin
      model_commit(m_pend_t, m_pend_c);
      m_pend = 1'b0;
    end
    d = m_k % DW;
    r = (m_k / DW) % 4;
    seen = m_colq.pop_front();
    m_colq.push_back(col_n);
    if (d == DW - 1) begin
      for (int c = 0; c < 3; c++)
        if (!seen[c]) begin m_hits++; m_code = LAYOUT[r*3+c]; end
      if (r == 3) begin
        t  = (m_hits == 0) ? R_NONE : (m_hits == 1) ? R_SINGLE : R_MULTI;
        cc = (t == R_SINGLE) ? m_code : 4'h0;
        if (t == m_cand_t && cc == m_cand_c) begin
          if (m_cnt < DC) begin
            m_cnt++;
            if (m_cnt == DC) m_pend = 1'b1;
          end
        end else begin
          m_cand_t = t; m_cand_c = cc; m_cnt = 1;
          if (DC == 1) m_pend = 1'b1;
        end
        m_pend_t = t; m_pend_c = cc;
        m_hits = 0; m_code = 4'h0;
      end
    end
    m_k++;
    m_row = ~(4'b0001 << 2'((m_k / DW) % 4));
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (!rst)
      chk("outputs{row_n,kv,code,mk}", {22'd0, row_n, key_valid, key_code, multi_key},
          {22'd0, m_row, m_kv, m_key, m_mk});
  end

  // Activity monitor
  logic       kv_prev = 1'b0;
  logic [5:0] prev_out = 6'd0;
  int         kv_rises = 0, out_changes = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid && !kv_prev) kv_rises++;
      if ({key_valid, key_code, multi_key} != prev_out) out_changes++;
    end
    kv_prev  = key_valid;
    prev_out = {key_valid, key_code, multi_key};
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Wait (bounded) until key_valid or multi_key equals val; lat = posedges elapsed
  task automatic wait_for(input bit use_mk, input logic val, input int budget, output int lat);
    lat = 0;
    while (((use_mk ? multi_key : key_valid) !== val) && lat < budget) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
  endtask

  // Return at the negedge just after row 0 starts being driven
  task automatic align_scan();
    int n;
    n = 0;
    while (row_n != 4'b0111 && n < 64) begin @(negedge clk); n++; end
    while (row_n != 4'b1110 && n < 128) begin @(negedge clk); n++; end
  endtask

  int lat, rise0, oc0, i1, i2;

  initial begin
    rst = 1'b1;
    pressed = 12'd0;
    repeat (3) @(negedge clk);
    chk("reset key_valid", key_valid, 1'b0);
    chk("reset key_code", key_code, 4'h0);
    chk("reset multi_key", multi_key, 1'b0);
    chk("reset row_n", row_n, 4'b1110);
    rst = 1'b0;

    // 1: idle scan, rows step every DW cycles and wrap
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      if (e % DW == 0) chk("row_n sequence", row_n, ROW_SEQ[(e / DW) % 4]);
    end
    chk("idle key_valid", key_valid, 1'b0);

    // 2: clean '5', latency window on press and release
    align_scan();
    pressed[4] = 1'b1;
    wait_for(0, 1'b1, 200, lat);
    chk_range("press5 latency", lat, 96, 131);
    chk("press5 code", key_code, 4'h5);
    repeat (50) @(negedge clk);
    align_scan();
    pressed[4] = 1'b0;
    wait_for(0, 1'b0, 200, lat);
    chk_range("release5 latency", lat, 96, 131);
    chk("release5 code held", key_code, 4'h5);

    // 3: bounce on '#' then stable hold
    repeat ($urandom_range(0, 31)) @(negedge clk);
    rise0 = kv_rises;
    oc0 = out_changes;
    for (int i = 0; i < 30; i++) begin
      pressed[11] = ~pressed[11];
      repeat (10) @(negedge clk);
    end
    chk("bounce output changes", out_changes - oc0, 0);
    pressed[11] = 1'b1;
    wait_for(0, 1'b1, 200, lat);
    chk("hash key_valid", key_valid, 1'b1);
    chk("hash code", key_code, 4'hB);
    repeat (100) @(negedge clk);
    chk("hash single rise", kv_rises - rise0, 1);
    pressed[11] = 1'b0;
    wait_for(0, 1'b0, 200, lat);

    // 4: '1'+'9' together, then '0'
    pressed[0] = 1'b1; pressed[8] = 1'b1;
    wait_for(1, 1'b1, 200, lat);
    chk("multi multi_key", multi_key, 1'b1);
    chk("multi key_valid", key_valid, 1'b0);
    pressed[0] = 1'b0; pressed[8] = 1'b0;
    wait_for(1, 1'b0, 200, lat);
    chk("multi released", multi_key, 1'b0);
    pressed[10] = 1'b1;
    wait_for(0, 1'b1, 200, lat);
    chk("zero key_valid", key_valid, 1'b1);
    chk("zero code", key_code, 4'h0);
    pressed[10] = 1'b0;
    wait_for(0, 1'b0, 200, lat);

    // 5: rollover '7' -> '8'
    pressed[6] = 1'b1;
    wait_for(0, 1'b1, 200, lat);
    chk("seven code", key_code, 4'h7);
    pressed[6] = 1'b0; pressed[7] = 1'b1;
    wait_for(0, 1'b0, 200, lat);
    chk("rollover drops key_valid", key_valid, 1'b0);
    rise0 = kv_rises;
    repeat (200) @(negedge clk);
    chk("rollover no new rise", kv_rises - rise0, 0);
    chk("rollover code held", key_code, 4'h7);
    pressed[7] = 1'b0;
    repeat (200) @(negedge clk);
    pressed[7] = 1'b1;
    wait_for(0, 1'b1, 200, lat);
    chk("eight code", key_code, 4'h8);
    pressed[7] = 1'b0;
    wait_for(0, 1'b0, 200, lat);

    // 6: async reset mid-press of '3'
    pressed[2] = 1'b1;
    wait_for(0, 1'b1, 200, lat);
    chk("three before reset", key_valid, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst key_valid", key_valid, 1'b0);
    chk("async rst key_code", key_code, 4'h0);
    chk("async rst row_n", row_n, 4'b1110);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_for(0, 1'b1, 200, lat);
    chk_range("three after reset latency", lat, 96, 131);
    chk("three code", key_code, 4'h3);
    pressed[2] = 1'b0;
    wait_for(0, 1'b0, 200, lat);

    // Randomized single and double presses
    for (int n = 0; n < 8; n++) begin
      i1 = $urandom_range(0, 11);
      i2 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 11) : i1;
      repeat ($urandom_range(0, 40)) @(negedge clk);
      pressed[i1] = 1'b1;
      pressed[i2] = 1'b1;
      repeat (140 + $urandom_range(0, 60)) @(negedge clk);
      if (i1 == i2) begin
        chk("rand single key_valid", key_valid, 1'b1);
        chk("rand single code", key_code, LAYOUT[i1]);
      end else begin
        chk("rand multi multi_key", multi_key, 1'b1);
        chk("rand multi key_valid", key_valid, 1'b0);
      end
      pressed = 12'd0;
      repeat (140 + $urandom_range(0, 60)) @(negedge clk);
      chk("rand released", {key_valid, multi_key}, 2'b00);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
